// File: rtl/csr_pkg.sv
// Shared CSR constants: addresses, access-op encoding, mstatus bit positions
// and the per-bit write/set/clear helper.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  function automatic logic csr_apply(input csr_op_e op, input logic q, input logic d);
    case (op)
      CSR_OP_WRITE: csr_apply = d;
      CSR_OP_SET:   csr_apply = q | d;
      CSR_OP_CLEAR: csr_apply = q & ~d;
      default:      csr_apply = q;
    endcase
  endfunction

endpackage

// File: rtl/csrfield.sv
// Single-bit CSR field with software write plus trap push / mret pop loads.
module csrfield (
  input  logic clk,
  input  logic rst_n,
  input  logic wr,
  input  logic wr_d,
  input  logic push,
  input  logic push_d,
  input  logic pop,
  input  logic pop_d,
  output logic q
);

  // Caller already resolves trap > mret > access; the order here just mirrors it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= 1'b0;
    else if (push) q <= push_d;
    else if (pop)  q <= pop_d;
    else if (wr)   q <= wr_d;
  end

endmodule

// File: rtl/csr_mstatus_stack.sv
// mstatus with a DEPTH-deep interrupt-enable stack: MIE on top, stack[0] is MPIE.
// Traps push, MRET pops, CSR accesses touch only the WMASK bits.
module csr_mstatus_stack
  import csr_pkg::*;
#(
  parameter logic [11:0] ADDRESS = CSR_MSTATUS,
  parameter int          DEPTH   = 1,
  parameter logic [31:0] WMASK   = 32'h0000_0088
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [11:0]      addr_i,
  input  logic [1:0]       op_i,
  input  logic [31:0]      wdata_i,
  input  logic             trap_i,
  input  logic             mret_i,
  output logic             ack_o,
  output logic [31:0]      value_o,
  output logic [DEPTH-1:0] stack_o,
  output logic [3:0]       level_o,
  output logic             overflow_o
);

  localparam logic [3:0] LVL_MAX = 4'(DEPTH);

  csr_op_e          op;
  logic             push, pop, acc;
  logic             mie;
  logic [DEPTH-1:0] stk;
  logic [DEPTH:0]   stk_up;   // {stack, MIE}: push source for stack[i] is stk_up[i]
  logic [DEPTH:0]   stk_dn;   // {1, stack}:   pop source for stack[i] is stk_dn[i+1]
  logic [3:0]       level_q;
  logic             ovf_q;
  logic             unused_wdata;

  assign op     = csr_op_e'(op_i);
  assign ack_o  = en_i && (addr_i == ADDRESS) && !trap_i;
  assign push   = trap_i;
  assign pop    = mret_i && !trap_i;
  // An acked access coinciding with MRET is still acked but has no effect.
  assign acc    = ack_o && !mret_i && (op != CSR_OP_NONE);
  assign stk_up = {stk, mie};
  assign stk_dn = {1'b1, stk};
  assign unused_wdata = ^wdata_i;

  csrfield u_mie (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .wr     (acc && WMASK[MSTATUS_MIE]),
    .wr_d   (csr_apply(op, mie, wdata_i[MSTATUS_MIE])),
    .push   (push),
    .push_d (1'b0),
    .pop    (pop),
    .pop_d  (stk[0]),
    .q      (mie)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_stk
    csrfield u_fld (
      .clk    (clk_i),
      .rst_n  (rst_i),
      .wr     (acc && WMASK[MSTATUS_MPIE] && (i == 0)),
      .wr_d   (csr_apply(op, stk[i], wdata_i[MSTATUS_MPIE])),
      .push   (push),
      .push_d (stk_up[i]),
      .pop    (pop),
      .pop_d  (stk_dn[i+1]),
      .q      (stk[i])
    );
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else if (push) begin
      if (level_q == LVL_MAX) ovf_q <= 1'b1;
      else                    level_q <= level_q + 4'd1;
    end else if (pop) begin
      if (level_q != 4'd0) level_q <= level_q - 4'd1;
    end else if (acc && (op == CSR_OP_CLEAR) && wdata_i[31]) begin
      ovf_q <= 1'b0;
    end
  end

  always_comb begin
    value_o                                = '0;
    value_o[MSTATUS_MIE]                   = mie;
    value_o[MSTATUS_MPIE]                  = stk[0];
    value_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  assign stack_o    = stk;
  assign level_o    = level_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_csr_mstatus_stack.sv
// Directed bench: DEPTH=1 and DEPTH=2 instances share stimulus; expectations hand-derived.
module tb_csr_mstatus_stack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] addr = 12'h300;
  logic [1:0]  op = 2'b00;
  logic [31:0] wdata = '0;
  logic        trap = 1'b0;
  logic        mret = 1'b0;

  logic        a1, a2, o1, o2;
  logic [31:0] v1, v2;
  logic [0:0]  s1;
  logic [1:0]  s2;
  logic [3:0]  l1, l2;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  csr_mstatus_stack #(.DEPTH(1)) d1 (
    .clk_i(clk), .rst_i(rst_n), .en_i(en), .addr_i(addr), .op_i(op), .wdata_i(wdata),
    .trap_i(trap), .mret_i(mret), .ack_o(a1), .value_o(v1), .stack_o(s1),
    .level_o(l1), .overflow_o(o1)
  );

  csr_mstatus_stack #(.DEPTH(2)) d2 (
    .clk_i(clk), .rst_i(rst_n), .en_i(en), .addr_i(addr), .op_i(op), .wdata_i(wdata),
    .trap_i(trap), .mret_i(mret), .ack_o(a2), .value_o(v2), .stack_o(s2),
    .level_o(l2), .overflow_o(o2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; op = 2'b00; wdata = '0; addr = 12'h300; trap = 1'b0; mret = 1'b0;
  endtask

  task automatic csr(input logic [11:0] a, input logic [1:0] o, input logic [31:0] w);
    en = 1'b1; addr = a; op = o; wdata = w;
  endtask

  initial begin
    #2;
    check("rst_val_async", v1, 32'h0000_1800);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_val", v1, 32'h0000_1800);
    check("rst_lvl", 32'(l1), 32'd0);
    check("rst_ack", 32'(a1), 32'd0);
    check("rst_ovf", 32'(o2), 32'd0);

    // set MIE/MPIE, then trap, then mret
    csr(12'h300, 2'b10, 32'h88); #1;
    check("set_ack", 32'(a1), 32'd1);
    tick(); idle();
    check("set_val", v1, 32'h0000_1888);
    trap = 1'b1; tick(); idle();
    check("trap_val1", v1, 32'h0000_1880);
    check("trap_lvl1", 32'(l1), 32'd1);
    check("trap_val2", v2, 32'h0000_1880);
    mret = 1'b1; tick(); idle();
    check("mret_val1", v1, 32'h0000_1888);
    check("mret_lvl1", 32'(l1), 32'd0);
    check("mret_stk2", 32'(s2), 32'h3);

    // wrong address ignored
    csr(12'h301, 2'b01, 32'hFFFF_FFFF); #1;
    check("badaddr_ack", 32'(a1), 32'd0);
    tick(); idle();
    check("badaddr_val", v1, 32'h0000_1888);

    csr(12'h300, 2'b11, 32'h8); tick(); idle();
    check("clr_val", v1, 32'h0000_1880);
    csr(12'h300, 2'b01, 32'h0); tick(); idle();
    check("wr0_val", v1, 32'h0000_1800);
    csr(12'h300, 2'b00, 32'hFF); #1;
    check("nop_ack", 32'(a1), 32'd1);
    tick(); idle();
    check("nop_val", v1, 32'h0000_1800);

    // DEPTH=2: MIE=1, three traps overflow, two mrets
    csr(12'h300, 2'b10, 32'h8); tick(); idle();
    check("mie_set", v2, 32'h0000_1808);
    for (int i = 0; i < 3; i++) begin
      trap = 1'b1; tick(); idle();
    end
    check("ovf_lvl2", 32'(l2), 32'd2);
    check("ovf_flag2", 32'(o2), 32'd1);
    check("ovf_lvl1", 32'(l1), 32'd1);
    check("ovf_flag1", 32'(o1), 32'd1);
    check("ovf_val1", v1, 32'h0000_1800);
    for (int i = 0; i < 2; i++) begin
      mret = 1'b1; tick(); idle();
    end
    check("pop_lvl2", 32'(l2), 32'd0);
    check("pop_val2", v2, 32'h0000_1880);
    check("pop_stk2", 32'(s2), 32'h3);
    check("pop_ovf_sticky", 32'(o2), 32'd1);
    check("pop0_val1", v1, 32'h0000_1888);
    check("pop0_lvl1", 32'(l1), 32'd0);

    // overflow clear needs bit 31 on an acked clear
    csr(12'h300, 2'b11, 32'h8000_0000); tick(); idle();
    check("ovf_clr", 32'(o2), 32'd0);
    check("ovf_clr_val", v2, 32'h0000_1880);

    // access alongside mret: acked but dropped, pop applies
    csr(12'h300, 2'b01, 32'h0); mret = 1'b1; #1;
    check("mret_acc_ack", 32'(a1), 32'd1);
    tick(); idle();
    check("mret_acc_val1", v1, 32'h0000_1888);
    check("mret_acc_val2", v2, 32'h0000_1888);

    // access alongside trap: not acked, trap applies
    csr(12'h300, 2'b01, 32'hFFFF_FFFF); trap = 1'b1; #1;
    check("trap_acc_ack", 32'(a1), 32'd0);
    tick(); idle();
    check("trap_acc_val1", v1, 32'h0000_1880);
    check("trap_acc_lvl1", 32'(l1), 32'd1);
    check("trap_acc_ovf1", 32'(o1), 32'd0);
    check("trap_acc_val2", v2, 32'h0000_1880);

    // async reset mid-cycle during a trap
    trap = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_val", v2, 32'h0000_1800);
    check("arst_lvl", 32'(l2), 32'd0);
    check("arst_stk", 32'(s2), 32'd0);
    check("arst_ovf", 32'(o1), 32'd0);
    tick(); idle();
    check("arst_hold", v1, 32'h0000_1800);
    rst_n = 1'b1;
    tick();
    check("arst_rel_val", v1, 32'h0000_1800);
    check("arst_rel_lvl", 32'(l1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/csr_mstatus_stack.md
CSR_MSTATUS_STACK -- requirements
Module: csr_mstatus_stack

Interface
REQ-001 Parameter ADDRESS, default 12'h300, CSR address decoded by this block.
REQ-002 Parameter DEPTH, default 1, interrupt-enable stack depth (range 1..8); DEPTH=1 gives the plain MIE/MPIE pair.
REQ-003 Parameter WMASK, default 32'h0000_0088, software-writable bits of value_o; only bits 3 and 7 are legal members.
REQ-004 clk_i  input  1  sole clock, rising edge.
REQ-005 rst_i  input  1  asynchronous, active-low reset.
REQ-006 en_i  input  1  CSR access strobe from the decode stage.
REQ-007 addr_i  input  12  CSR address.
REQ-008 op_i  input  2  00 none, 01 write, 10 set, 11 clear.
REQ-009 wdata_i  input  32  operand for op_i.
REQ-010 trap_i  input  1  single-cycle trap-entry pulse.
REQ-011 mret_i  input  1  single-cycle MRET pulse.
REQ-012 ack_o  output  1  access accepted this cycle.
REQ-013 value_o  output  32  current mstatus read value.
REQ-014 stack_o  output  DEPTH  saved-enable stack; bit 0 is MPIE.
REQ-015 level_o  output  4  current nesting level, 0..DEPTH.
REQ-016 overflow_o  output  1  sticky overflow flag: a trap was taken at full depth.

Function
REQ-017 ack_o SHALL equal en_i AND (addr_i==ADDRESS) AND NOT trap_i, combinationally.
REQ-018 value_o SHALL be combinational: bit 3 = MIE, bit 7 = stack[0], bits 12:11 = 2'b11, all other bits 0.
REQ-019 On an acked access with op 01, each WMASK bit SHALL take wdata_i at the next clock edge.
REQ-020 On an acked access with op 10, each WMASK bit SHALL be set where wdata_i is 1.
REQ-021 On an acked access with op 11, each WMASK bit SHALL be cleared where wdata_i is 1.
REQ-022 Bits outside WMASK SHALL never change on a CSR access; op 00 SHALL change nothing.
REQ-023 trap_i (push) SHALL act at the next edge as follows:
- stack[i] <= stack[i-1] for i >= 1;
- stack[0] <= MIE;
- MIE <= 0;
- level_o increments, saturating at DEPTH.
REQ-024 A push at level_o==DEPTH SHALL discard stack[DEPTH-1] and set overflow_o.
REQ-025 mret_i (pop) SHALL act at the next edge as follows:
- MIE <= stack[0];
- stack[i] <= stack[i+1];
- stack[DEPTH-1] <= 1;
- level_o decrements, saturating at 0.
REQ-026 A pop at level_o==0 SHALL still perform the REQ-025 bit moves and leave level_o at 0.
REQ-027 Priority SHALL be trap_i over mret_i over CSR access. A simultaneous mret_i or CSR access SHALL be dropped with no effect, and ack_o=0 per REQ-017.
REQ-028 A CSR access and mret_i in the same cycle: the pop SHALL apply, the access SHALL be dropped, and ack_o SHALL still be 1.
REQ-029 overflow_o SHALL clear only on reset or on an acked op 11 whose wdata_i bit 31 is 1.
REQ-030 All state updates SHALL take one cycle; no multi-cycle operations.

Reset
REQ-031 While rst_i is low, the following SHALL hold asynchronously:
- MIE=0;
- stack all 0;
- level_o=0;
- overflow_o=0;
- value_o=32'h0000_1800.
REQ-032 A reset asserted mid-cycle SHALL discard any same-cycle push, pop or write.

Structure
REQ-033 A shared package csr_pkg SHALL hold:
- CSR address constants (MSTATUS=12'h300);
- the op_i encoding;
- mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
REQ-034 MIE and each stack bit SHALL be built as a single-bit field sub-module, csrfield, extended with push/pop load inputs.
REQ-035 The remaining RTL SHALL consist of the stack shift logic, the level counter and the priority mux.

Verification
REQ-036 Reset release, no stimulus -> value_o=32'h0000_1800, level_o=0, ack_o=0.
REQ-037 op 10 with wdata 32'h88, then trap_i -> value_o=32'h0000_1880, level_o=1; then mret_i -> value_o=32'h0000_1888, level_o=0.
REQ-038 DEPTH=2, MIE=1, three trap_i pulses -> level_o=2, overflow_o=1; then two mret_i -> level_o=0, MIE=0, stack_o=2'b11.
REQ-039 trap_i with an acked op 01 of wdata 32'hFFFF_FFFF -> ack_o=0, MIE=0, write dropped.
REQ-040 op 01 of wdata 32'hFFFF_FFFF at address 12'h301 -> ack_o=0, value_o unchanged.
REQ-041 rst_i pulled low between clock edges during a trap -> outputs reach reset values immediately, before the next edge.
